// File: rtl/aes_round_sequencer_if.sv
// aes_round_sequencer_if
// Bundles the control-side signals of the AES round sequencer.
//   master : host side (register block); drives Start/Abort/Decrypt.
//   slave  : sequencer side; drives status and datapath controls.
// Handshake: Start is a level request sampled only while the sequencer is
// idle; Done stays high until Start is seen low, which acts as the
// acknowledge. Abort cancels on any edge and wins over Start.
// fsm_state is a debug view of the sequencer state encoding.
interface aes_round_sequencer_if;
  logic       Start;
  logic       Abort;
  logic       Decrypt;
  logic       Done;
  logic       Busy;
  logic [3:0] Round;
  logic [3:0] Key_Idx;
  logic [1:0] Select;
  logic [1:0] MIX;
  logic       LD_STATE;
  logic       LD_STATE_MIX;
  logic [2:0] fsm_state;

  modport master (
    output Start, Abort, Decrypt,
    input  Done, Busy, Round, Key_Idx, Select, MIX, LD_STATE, LD_STATE_MIX,
    input  fsm_state
  );

  modport slave (
    input  Start, Abort, Decrypt,
    output Done, Busy, Round, Key_Idx, Select, MIX, LD_STATE, LD_STATE_MIX,
    output fsm_state
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Sequences AddRoundKey / SubBytes / ShiftRows / MixColumns for the AES
// encrypt or inverse cipher at 10, 12 or 14 rounds.
// Ports:
//   Clk    : clock
//   Reset  : synchronous, active-high reset
//   bus    : aes_round_sequencer_if.slave (Start/Abort/Decrypt in;
//            Done/Busy/Round/Key_Idx/Select/MIX/LD_STATE/LD_STATE_MIX out)
// Parameters:
//   NR_ROUNDS  : 10, 12 or 14
//   SUB_CYCLES : cycles per SubBytes step (>= 1)
//   MIX_PAR    : MixColumns columns per cycle (1, 2 or 4)
module aes_round_sequencer #(
  parameter int NR_ROUNDS  = 10,
  parameter int SUB_CYCLES = 2,
  parameter int MIX_PAR    = 1
) (
  input logic Clk,
  input logic Reset,
  aes_round_sequencer_if.slave bus
);

  localparam int MIX_CYCLES = 4 / MIX_PAR;
  localparam int CNT_MAX    = (SUB_CYCLES > MIX_CYCLES) ? SUB_CYCLES : MIX_CYCLES;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [3:0] NR4      = 4'(NR_ROUNDS);
  localparam logic [CW-1:0] SUB_LAST = CW'(SUB_CYCLES - 1);
  localparam logic [CW-1:0] MIX_LAST = CW'(MIX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADD, S_SUB, S_SHIFT, S_MIX, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  logic       done_q, busy_q, ld_q, ld_mix_q;
  logic [3:0] key_q;
  logic [1:0] sel_q, mix_q;

  // Next-state logic. Round reads 4'hF whenever the sequencer is parked
  // (IDLE/DONE) and is set to 0 as soon as a request is accepted, so the
  // key index never leaves 0..NR_ROUNDS while busy.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    cnt_d   = '0;
    mode_d  = mode_q;
    if (bus.Abort) begin
      state_d = S_IDLE;
      round_d = 4'hF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.Start) begin
            state_d = S_START;
            round_d = 4'd0;
            mode_d  = bus.Decrypt;
          end
        end
        S_START: begin
          state_d = S_ADD;
          round_d = 4'd0;
        end
        S_ADD: begin
          if (round_q == NR4) begin
            state_d = S_DONE;
            round_d = 4'hF;
          end else if (!mode_q) begin
            state_d = S_SUB;
            round_d = round_q + 4'd1;
          end else if (round_q == 4'd0) begin
            state_d = S_SHIFT;
            round_d = round_q + 4'd1;
          end else begin
            state_d = S_MIX;
          end
        end
        S_SUB: begin
          if (cnt_q == SUB_LAST) state_d = mode_q ? S_ADD : S_SHIFT;
          else                   cnt_d   = cnt_q + 1'b1;
        end
        S_SHIFT: begin
          if (mode_q)                 state_d = S_SUB;
          else if (round_q == NR4)    state_d = S_ADD;
          else                        state_d = S_MIX;
        end
        S_MIX: begin
          if (cnt_q == MIX_LAST) begin
            // The inverse cipher closes each round after MixColumns.
            if (mode_q) begin
              state_d = S_SHIFT;
              round_d = round_q + 4'd1;
            end else begin
              state_d = S_ADD;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (!bus.Start) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          round_d = 4'hF;
        end
      endcase
    end
  end

  // State and outputs are registered together; outputs are decoded from
  // the next-state values so they line up with the state they describe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      round_q  <= 4'hF;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      key_q    <= 4'd0;
      sel_q    <= 2'b00;
      mix_q    <= 2'd0;
      ld_q     <= 1'b0;
      ld_mix_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      done_q   <= (state_d == S_DONE);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      if ((state_d == S_IDLE) || (state_d == S_DONE)) key_q <= 4'd0;
      else if (mode_d)                                 key_q <= NR4 - round_d;
      else                                             key_q <= round_d;
      case (state_d)
        S_ADD:   sel_q <= 2'b10;
        S_SUB:   sel_q <= 2'b01;
        S_MIX:   sel_q <= 2'b11;
        default: sel_q <= 2'b00;
      endcase
      mix_q    <= (state_d == S_MIX) ? 2'(cnt_d * MIX_PAR) : 2'd0;
      ld_q     <= (state_d == S_ADD) || (state_d == S_SHIFT) ||
                  ((state_d == S_SUB) && (cnt_d == SUB_LAST));
      ld_mix_q <= (state_d == S_MIX);
    end
  end

  assign bus.Done         = done_q;
  assign bus.Busy         = busy_q;
  assign bus.Round        = round_q;
  assign bus.Key_Idx      = key_q;
  assign bus.Select       = sel_q;
  assign bus.MIX          = mix_q;
  assign bus.LD_STATE     = ld_q;
  assign bus.LD_STATE_MIX = ld_mix_q;
  assign bus.fsm_state    = state_q;

endmodule
